// File: rtl/saturn_bus_controller.sv
// Saturn nibble bus controller: 24-nibble prefetch queue plus data read/RMW-write sequencer.
// Define BUS_CTRL_TRISTATE_EN to drive and sample the bus through bus_data_io.
module saturn_bus_controller (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic [19:0] bus_addr_o,
    output logic        bus_rd_o,
    output logic        bus_we_o,
    input  logic [15:0] bus_data_in,
    output logic [15:0] bus_data_o,
    inout  wire  [15:0] bus_data_io,
    input  logic [19:0] ibus_addr_in,
    input  logic        ibus_flush_q_in,
    input  logic        ibus_fetch_in,
    input  logic        ibus_fetch_ack_in,
    input  logic [4:0]  ibus_size_in,
    output logic [83:0] ibus_pre_fetched_opcode_o,
    output logic [4:0]  ibus_pre_fetched_opcode_length_o,
    output logic [19:0] ibus_addr_o,
    output logic        ibus_ready_o,
    input  logic [19:0] data_addr_in,
    input  logic [3:0]  data_size_in,
    input  logic [63:0] data_data_in,
    input  logic [15:0] data_mask_in,
    input  logic        data_rd_in,
    input  logic        data_wr_in,
    output logic [63:0] data_data_o,
    output logic        data_ready_o
);
    typedef enum logic [2:0] {IDLE, RD, WR_RD, WR_WR, DONE} state_t;

    state_t      state;
    logic [15:0] rdata;
    logic [95:0] q, q_pop, q_next;
    logic [4:0]  count, cnt_pop, cnt_next, sz;
    logic [1:0]  skip;
    logic [19:0] fptr;
    logic        pf_pend, pf_ok, pop;
    logic [15:0] app;
    logic [19:0] d_base;
    logic [1:0]  d_off;
    logic [3:0]  d_size;
    logic [63:0] d_data;
    logic [15:0] d_mask;
    logic [2:0]  d_last, widx, first, wnext;
    logic [79:0] rbuf, nbuf, shifted, wdata;
    logic [19:0] wm, wm_new, base_new;
    logic [4:0]  span_new;
    logic [63:0] smask, rd_result;
    logic [15:0] merged;

`ifdef BUS_CTRL_TRISTATE_EN
    assign bus_data_io = bus_we_o ? bus_data_o : 16'bz;
    assign rdata = bus_data_io;
    wire unused_in = ^bus_data_in;
`else
    assign bus_data_io = 16'bz;
    assign rdata = bus_data_in;
`endif
    wire unused_bits = ^{q[95:84], shifted[79:64]};

    // Per-nibble enables placed at their word-relative position, limited to the size.
    function automatic logic [19:0] word_mask(input logic [15:0] m,
                                              input logic [3:0] s,
                                              input logic [1:0] off);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m[i] && (4'(i) <= s);
        return {4'b0, v} << off;
    endfunction

    // First word index >= from holding an enabled nibble; 5 means none.
    function automatic logic [2:0] next_word(input logic [19:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = 3'd5;
        for (int w = 4; w >= 0; w--)
            if (3'(w) >= from && |m[4*w +: 4]) r = 3'(w);
        return r;
    endfunction

    assign ibus_pre_fetched_opcode_o = q[83:0];
    assign ibus_pre_fetched_opcode_length_o = count;
    assign ibus_ready_o = (count != 5'd0) && (count >= ibus_size_in);

    always_comb begin
        pop = ibus_fetch_ack_in && ibus_ready_o && !ibus_flush_q_in;
        sz = pop ? ibus_size_in : 5'd0;
        q_pop = q >> {sz, 2'b00};
        cnt_pop = count - sz;
        app = rdata >> {skip, 2'b00};
        q_next = q_pop;
        cnt_next = cnt_pop;
        if (pf_pend) begin
            q_next = q_pop | ({80'b0, app} << {cnt_pop, 2'b00});
            cnt_next = cnt_pop + (5'd4 - {3'b0, skip});
        end
        pf_ok = ibus_fetch_in && !ibus_flush_q_in && state == IDLE
             && !data_rd_in && !data_wr_in
             && ({1'b0, count} + (pf_pend ? 6'd4 : 6'd0) <= 6'd20);
    end

    always_comb begin
        base_new = {data_addr_in[19:2], 2'b00};
        span_new = {3'b0, data_addr_in[1:0]} + {1'b0, data_size_in};
        wm_new = word_mask(data_mask_in, data_size_in, data_addr_in[1:0]);
        first = next_word(wm_new, 3'd0);
        wm = word_mask(d_mask, d_size, d_off);
        wnext = next_word(wm, widx + 3'd1);
        wdata = {16'b0, d_data} << {d_off, 2'b00};
        nbuf = rbuf;
        nbuf[16*widx +: 16] = rdata;
        shifted = nbuf >> {d_off, 2'b00};
        for (int i = 0; i < 16; i++)
            smask[4*i +: 4] = (4'(i) <= d_size) ? 4'hf : 4'h0;
        rd_result = shifted[63:0] & smask;
        for (int k = 0; k < 4; k++)
            merged[4*k +: 4] = wm[4*widx + k] ? wdata[16*widx + 4*k +: 4]
                                              : rdata[4*k +: 4];
    end

    // Prefetch queue; a flush drops any word returning in the same cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            q <= '0;
            count <= '0;
            skip <= '0;
            ibus_addr_o <= '0;
        end else if (ibus_flush_q_in) begin
            q <= '0;
            count <= '0;
            skip <= ibus_addr_in[1:0];
            ibus_addr_o <= ibus_addr_in;
        end else begin
            q <= q_next;
            count <= cnt_next;
            ibus_addr_o <= ibus_addr_o + {15'b0, sz};
            if (pf_pend) skip <= 2'd0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            bus_addr_o <= '0;
            bus_rd_o <= 1'b0;
            bus_we_o <= 1'b0;
            bus_data_o <= '0;
            data_data_o <= '0;
            data_ready_o <= 1'b0;
            fptr <= '0;
            pf_pend <= 1'b0;
            d_base <= '0;
            d_off <= '0;
            d_size <= '0;
            d_data <= '0;
            d_mask <= '0;
            d_last <= '0;
            widx <= '0;
            rbuf <= '0;
        end else begin
            bus_rd_o <= 1'b0;
            bus_we_o <= 1'b0;
            data_ready_o <= 1'b0;
            pf_pend <= 1'b0;
            if (ibus_flush_q_in) fptr <= {ibus_addr_in[19:2], 2'b00};
            case (state)
                IDLE: begin
                    if (data_rd_in || data_wr_in) begin
                        d_base <= base_new;
                        d_off <= data_addr_in[1:0];
                        d_size <= data_size_in;
                        d_data <= data_data_in;
                        d_mask <= data_mask_in;
                        d_last <= span_new[4:2];
                        if (data_rd_in) begin
                            state <= RD;
                            bus_rd_o <= 1'b1;
                            bus_addr_o <= base_new;
                            widx <= 3'd0;
                        end else if (first == 3'd5) begin
                            state <= DONE;
                            data_ready_o <= 1'b1;
                        end else begin
                            state <= WR_RD;
                            bus_rd_o <= 1'b1;
                            bus_addr_o <= base_new + {15'b0, first, 2'b00};
                            widx <= first;
                        end
                    end else if (pf_ok) begin
                        bus_rd_o <= 1'b1;
                        bus_addr_o <= fptr;
                        fptr <= fptr + 20'd4;
                        pf_pend <= 1'b1;
                    end
                end
                RD: begin
                    rbuf <= nbuf;
                    if (widx == d_last) begin
                        state <= DONE;
                        data_ready_o <= 1'b1;
                        data_data_o <= rd_result;
                    end else begin
                        widx <= widx + 3'd1;
                        bus_rd_o <= 1'b1;
                        bus_addr_o <= d_base + {15'b0, widx + 3'd1, 2'b00};
                    end
                end
                WR_RD: begin
                    bus_we_o <= 1'b1;
                    bus_data_o <= merged;
                    state <= WR_WR;
                end
                WR_WR: begin
                    if (wnext == 3'd5) begin
                        state <= DONE;
                        data_ready_o <= 1'b1;
                    end else begin
                        state <= WR_RD;
                        bus_rd_o <= 1'b1;
                        bus_addr_o <= d_base + {15'b0, wnext, 2'b00};
                        widx <= wnext;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_saturn_bus_controller.sv
// Directed bench for saturn_bus_controller with a queue scoreboard on bus and ready events.
// Unwritten memory returns nibble value = address[3:0].
`timescale 1ns/1ps
module tb_saturn_bus_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] bus_addr_o;
    logic        bus_rd_o, bus_we_o;
    logic [15:0] bus_data_in;
    logic [15:0] bus_data_o;
    wire  [15:0] bus_data_io;
    logic [19:0] ibus_addr_in = '0;
    logic        ibus_flush_q_in = 1'b0;
    logic        ibus_fetch_in = 1'b1;
    logic        ibus_fetch_ack_in = 1'b0;
    logic [4:0]  ibus_size_in = '0;
    logic [83:0] opcode;
    logic [4:0]  olen;
    logic [19:0] ibus_addr_o;
    logic        ibus_ready_o;
    logic [19:0] data_addr_in = '0;
    logic [3:0]  data_size_in = '0;
    logic [63:0] data_data_in = '0;
    logic [15:0] data_mask_in = '0;
    logic        data_rd_in = 1'b0;
    logic        data_wr_in = 1'b0;
    logic [63:0] data_data_o;
    logic        data_ready_o;

    int n_tests = 0;
    int n_fail = 0;
    logic [19:0] exp_rd[$];
    logic [35:0] exp_wr[$];
    logic [64:0] exp_rdy[$];
    logic [15:0] mem[int];

    saturn_bus_controller dut (
        .clk_in(clk), .rst_n_in(rst_n),
        .bus_addr_o(bus_addr_o), .bus_rd_o(bus_rd_o), .bus_we_o(bus_we_o),
        .bus_data_in(bus_data_in), .bus_data_o(bus_data_o), .bus_data_io(bus_data_io),
        .ibus_addr_in(ibus_addr_in), .ibus_flush_q_in(ibus_flush_q_in),
        .ibus_fetch_in(ibus_fetch_in), .ibus_fetch_ack_in(ibus_fetch_ack_in),
        .ibus_size_in(ibus_size_in), .ibus_pre_fetched_opcode_o(opcode),
        .ibus_pre_fetched_opcode_length_o(olen), .ibus_addr_o(ibus_addr_o),
        .ibus_ready_o(ibus_ready_o), .data_addr_in(data_addr_in),
        .data_size_in(data_size_in), .data_data_in(data_data_in),
        .data_mask_in(data_mask_in), .data_rd_in(data_rd_in), .data_wr_in(data_wr_in),
        .data_data_o(data_data_o), .data_ready_o(data_ready_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_word(input logic [19:0] a);
        logic [15:0] w;
        if (mem.exists(int'(a))) return mem[int'(a)];
        for (int i = 0; i < 4; i++) w[4*i +: 4] = a[3:0] + 4'(i);
        return w;
    endfunction

    task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: memory model plus scoreboard pops on every DUT event.
    always @(negedge clk) begin
        bus_data_in = rd_word(bus_addr_o);
        if (rst_n) begin
            if (bus_rd_o) begin
                if (exp_rd.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_rd: got addr %0h expected none", bus_addr_o);
                end else check("rd_addr", 84'(bus_addr_o), 84'(exp_rd.pop_front()));
            end
            if (bus_we_o) begin
                mem[int'(bus_addr_o)] = bus_data_o;
                if (exp_wr.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_wr: got %0h:%0h expected none", bus_addr_o, bus_data_o);
                end else check("wr_addr_data", 84'({bus_addr_o, bus_data_o}), 84'(exp_wr.pop_front()));
            end
            if (data_ready_o) begin
                if (exp_rdy.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_ready: got pulse expected none");
                end else begin
                    logic [64:0] e;
                    e = exp_rdy.pop_front();
                    if (e[64]) check("rd_result", 84'(data_data_o), 84'(e[63:0]));
                end
            end
        end
    end

    task automatic do_data(input logic rd, input logic wr, input logic [19:0] a,
                           input logic [3:0] s, input logic [63:0] d, input logic [15:0] m);
        bit seen;
        seen = 0;
        @(negedge clk);
        data_rd_in = rd; data_wr_in = wr; data_addr_in = a;
        data_size_in = s; data_data_in = d; data_mask_in = m;
        @(negedge clk);
        data_rd_in = 0; data_wr_in = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (data_ready_o) seen = 1;
            else @(negedge clk);
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL data_timeout: got no ready expected pulse (addr %0h)", a);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 6; i++) exp_rd.push_back(20'(4 * i));
        repeat (3) @(negedge clk);
        check("reset_len", 84'(olen), 84'd0);
        check("reset_iaddr", 84'(ibus_addr_o), 84'd0);
        check("reset_rd", 84'(bus_rd_o), 84'd0);
        check("reset_ready", 84'(data_ready_o), 84'd0);
        rst_n = 1;
        @(negedge clk);
        check("first_rd", 84'(bus_rd_o), 84'd1);
        @(negedge clk);
        check("len_after_first", 84'(olen), 84'd4);
        check("op_first", 84'(opcode[15:0]), 84'h3210);
        repeat (8) @(negedge clk);
        check("full_len", 84'(olen), 84'd24);
        check("full_op", opcode, {20'h43210, 64'hFEDCBA9876543210});
        check("full_rd_idle", 84'(bus_rd_o), 84'd0);
        ibus_size_in = 5'd21;
        #1 check("ready_21", 84'(ibus_ready_o), 84'd1);
        ibus_fetch_in = 0;

        // Flush to unaligned address drops the leading nibbles
        exp_rd.push_back(20'h4);
        @(negedge clk); ibus_flush_q_in = 1; ibus_addr_in = 20'h6; ibus_fetch_in = 1;
        @(negedge clk); ibus_flush_q_in = 0;
        check("flush_len", 84'(olen), 84'd0);
        check("flush_iaddr", 84'(ibus_addr_o), 84'h6);
        @(negedge clk); ibus_fetch_in = 0;
        @(negedge clk);
        check("flush_fill_len", 84'(olen), 84'd2);
        check("flush_op", opcode, 84'h76);
        check("flush_iaddr2", 84'(ibus_addr_o), 84'h6);

        // Fill 8 nibbles, then ack 5 and an over-size ack
        exp_rd.push_back(20'h10); exp_rd.push_back(20'h14);
        @(negedge clk); ibus_flush_q_in = 1; ibus_addr_in = 20'h10;
        @(negedge clk); ibus_flush_q_in = 0; ibus_fetch_in = 1;
        @(negedge clk);
        @(negedge clk); ibus_fetch_in = 0;
        @(negedge clk);
        check("len8", 84'(olen), 84'd8);
        ibus_size_in = 5'd5;
        #1 check("ready_5", 84'(ibus_ready_o), 84'd1);
        ibus_fetch_ack_in = 1;
        @(negedge clk); ibus_fetch_ack_in = 0;
        check("ack5_len", 84'(olen), 84'd3);
        check("ack5_iaddr", 84'(ibus_addr_o), 84'h15);
        check("ack5_op", opcode, 84'h765);
        ibus_size_in = 5'd9;
        #1 check("ready_9", 84'(ibus_ready_o), 84'd0);
        ibus_fetch_ack_in = 1;
        @(negedge clk); ibus_fetch_ack_in = 0;
        check("ack9_len", 84'(olen), 84'd3);
        check("ack9_iaddr", 84'(ibus_addr_o), 84'h15);

        // Pop and append in the same cycle
        exp_rd.push_back(20'h18);
        ibus_size_in = 5'd2; ibus_fetch_in = 1;
        @(negedge clk); ibus_fetch_in = 0; ibus_fetch_ack_in = 1;
        @(negedge clk); ibus_fetch_ack_in = 0;
        check("popapp_len", 84'(olen), 84'd5);
        check("popapp_iaddr", 84'(ibus_addr_o), 84'h17);
        check("popapp_op", opcode, 84'hBA987);

        // Flush beats ack
        ibus_flush_q_in = 1; ibus_addr_in = 20'h0; ibus_fetch_ack_in = 1; ibus_size_in = 5'd1;
        @(negedge clk); ibus_flush_q_in = 0; ibus_fetch_ack_in = 0;
        check("flushack_len", 84'(olen), 84'd0);
        check("flushack_iaddr", 84'(ibus_addr_o), 84'h0);

        // Data read spanning two words
        exp_rd.push_back(20'h0); exp_rd.push_back(20'h4);
        exp_rdy.push_back({1'b1, 64'h6543});
        do_data(1, 0, 20'h3, 4'd3, 64'h0, 16'h0);

        // Single-nibble RMW write
        exp_rd.push_back(20'h0);
        exp_wr.push_back({20'h0, 16'h3510});
        exp_rdy.push_back({1'b0, 64'h0});
        do_data(0, 1, 20'h2, 4'd1, 64'hA5, 16'h0001);

        // Five-word write with two skipped words
        exp_rd.push_back(20'hC); exp_rd.push_back(20'h18); exp_rd.push_back(20'h1C);
        exp_wr.push_back({20'hC, 16'hFFDC});
        exp_wr.push_back({20'h18, 16'hBA95});
        exp_wr.push_back({20'h1C, 16'hFE0C});
        exp_rdy.push_back({1'b0, 64'h0});
        do_data(0, 1, 20'hE, 4'd15, 64'h0123456789ABCDEF, 16'h8401);

        // Read wins over write; address wraps
        exp_rd.push_back(20'hFFFFC); exp_rd.push_back(20'h0);
        exp_rdy.push_back({1'b1, 64'h10FE});
        do_data(1, 1, 20'hFFFFE, 4'd3, 64'h0, 16'hFFFF);

        // Full 16-nibble read
        for (int i = 0; i < 4; i++) exp_rd.push_back(20'(4 * i));
        exp_rdy.push_back({1'b1, 64'hFFDCBA9876543510});
        do_data(1, 0, 20'h0, 4'd15, 64'h0, 16'h0);

        // Reset mid-read abandons it without a ready pulse
        exp_rd.push_back(20'h40);
        @(negedge clk); data_rd_in = 1; data_addr_in = 20'h40; data_size_in = 4'd7;
        @(negedge clk); data_rd_in = 0;
        @(posedge clk); #2 rst_n = 0;
        repeat (3) @(negedge clk);
        check("midrst_rd", 84'(bus_rd_o), 84'd0);
        check("midrst_data", 84'(data_data_o), 84'd0);
        rst_n = 1;
        repeat (6) @(negedge clk);
        check("midrst_len", 84'(olen), 84'd0);

        check("sb_rd_left", 84'(exp_rd.size()), 84'd0);
        check("sb_wr_left", 84'(exp_wr.size()), 84'd0);
        check("sb_rdy_left", 84'(exp_rdy.size()), 84'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/saturn_bus_controller.md
SATURN_BUS_CONTROLLER -- requirements
Module: saturn_bus_controller

Interface
REQ-001 SHALL have port clk_in, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port bus_addr_o, output, 20 bits: nibble address of the bus word; bits [1:0] always 0.
REQ-004 SHALL have port bus_rd_o, output, 1 bit: one-cycle word read strobe.
REQ-005 SHALL have port bus_we_o, output, 1 bit: one-cycle word write strobe.
REQ-006 SHALL have port bus_data_in, input, 16 bits: read word; nibble at address A+i is bits [4i+3:4i].
REQ-007 SHALL have port bus_data_o, output, 16 bits: write word, same nibble order as bus_data_in.
REQ-008 SHALL have port bus_data_io, inout, 16 bits: tristate data bus (see REQ-043).
REQ-009 SHALL have port ibus_addr_in, input, 20 bits: nibble target address loaded on flush.
REQ-010 SHALL have port ibus_flush_q_in, input, 1 bit: flush the prefetch queue and restart at ibus_addr_in.
REQ-011 SHALL have port ibus_fetch_in, input, 1 bit: prefetch enable.
REQ-012 SHALL have port ibus_fetch_ack_in, input, 1 bit: consume ibus_size_in nibbles from the queue head.
REQ-013 SHALL have port ibus_size_in, input, 5 bits: nibbles required or consumed (0..21).
REQ-014 SHALL have port ibus_pre_fetched_opcode_o, output, 84 bits: first 21 queued nibbles, head nibble in [3:0], invalid nibbles 0.
REQ-015 SHALL have port ibus_pre_fetched_opcode_length_o, output, 5 bits: valid nibble count (0..24).
REQ-016 SHALL have port ibus_addr_o, output, 20 bits: nibble address of the queue head.
REQ-017 SHALL have port ibus_ready_o, output, 1 bit: high when count != 0 and count >= ibus_size_in.
REQ-018 SHALL have port data_addr_in, input, 20 bits: data nibble start address.
REQ-019 SHALL have port data_size_in, input, 4 bits: nibble count minus 1 (1..16 nibbles).
REQ-020 SHALL have port data_data_in, input, 64 bits: write nibbles, first nibble in [3:0].
REQ-021 SHALL have port data_mask_in, input, 16 bits: per-nibble write enable, bit i gates nibble i.
REQ-022 SHALL have port data_rd_in, input, 1 bit: data read request, sampled only when idle.
REQ-023 SHALL have port data_wr_in, input, 1 bit: data write request, sampled only when idle; data_rd_in wins if both are high.
REQ-024 SHALL have port data_data_o, output, 64 bits: read result, first nibble in [3:0]; nibbles beyond size are 0.
REQ-025 SHALL have port data_ready_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-026 SHALL complete a bus access in one cycle: strobe and address driven for one cycle, bus_data_in sampled on the edge ending it; at most one access per cycle.
REQ-027 SHALL keep a 24-nibble prefetch FIFO plus a 20-bit word-aligned fetch pointer; all addresses wrap modulo 2^20.
REQ-028 SHALL issue a prefetch read at the fetch pointer whenever ibus_fetch_in=1, free space >= 4 nibbles, no data transaction is active and no flush is present; back-to-back reads are permitted.
REQ-029 SHALL append the 4 fetched nibbles and advance the fetch pointer by 4.
REQ-030 SHALL, on flush, empty the queue, set fetch pointer = ibus_addr_in & ~3 and ibus_addr_o = ibus_addr_in, and drop the first ibus_addr_in[1:0] nibbles of the next fetched word.
REQ-031 SHALL discard data returned in the flush cycle; flush has priority over ack in the same cycle.
REQ-032 SHALL, on ack while ibus_ready_o=1, pop ibus_size_in nibbles and advance ibus_addr_o by that amount; an ack while not ready is ignored.
REQ-033 SHALL allow a pop and an append in the same cycle, with the count = old - size + appended.
REQ-034 SHALL give data transactions priority over prefetch once started; a prefetch is never aborted mid-cycle.
REQ-035 SHALL perform a data read as sequential word reads covering [addr, addr+size], then assemble, zero-fill and pulse data_ready_o one cycle after the last read.
REQ-036 SHALL perform a data write per covered word as a read-modify-write: read, merge enabled nibbles, write in the next cycle; words with no enabled nibble are skipped; data_ready_o pulses after the final write.
REQ-037 SHALL not snoop writes against the queue; software flushes after self-modifying writes.
REQ-038 SHALL implement data sequencing with FSM states IDLE, RD, WR_RD, WR_WR, DONE; DONE returns to IDLE.
REQ-039 SHALL leave an active data transaction unaffected by a flush.

Reset
REQ-040 SHALL, while rst_n_in=0, clear all outputs, empty the queue, set fetch pointer and ibus_addr_o to 0 and the FSM to IDLE.
REQ-041 SHALL abandon any in-flight transaction at reset without a data_ready_o pulse.
REQ-042 SHALL issue the first prefetch in the first cycle after reset release when ibus_fetch_in=1.

Configuration
REQ-043 SHALL, with BUS_CTRL_TRISTATE_EN defined, drive bus_data_io with bus_data_o while bus_we_o=1, else high-Z, and source read data from bus_data_io; without the macro, bus_data_io stays high-Z and reads use bus_data_in.

Verification
REQ-044 SHALL verify: word@0=0x3210, fetch=1 after reset -> cycle 1 bus_rd_o=1, addr 0x00000; then length=4, opcode[15:0]=0x3210.
REQ-045 SHALL verify: fetch=1, no ack -> exactly 6 reads (0x00000..0x00014), length=24, bus_rd_o stays 0.
REQ-046 SHALL verify: flush to 0x00006 -> next read at 0x00004, length=2, ibus_addr_o=0x00006, opcode[7:0] = word nibbles 3:2.
REQ-047 SHALL verify: length=8, ack size=5 -> length=3, ibus_addr_o advanced by 5; size=9 -> ready=0, ack ignored.
REQ-048 SHALL verify: data read addr 0x00003 size=3 -> reads 0x00000 and 0x00004, data_data_o[15:0] = nibbles 3..6, upper bits 0, one ready pulse.
REQ-049 SHALL verify: write addr 0x00002 size=1 mask=0x0001 -> read 0x00000, write the word with only nibble 2 replaced, ready pulse.
